// File: rtl/mul_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mul_ctrl_pkg
//
// Op codes for the multiply class and a small decoder that sorts an EX-stage
// op code into its multiply "kind" and signedness.
// ---------------------------------------------------------------------------
package mul_ctrl_pkg;

    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

    // What happens to the product once it returns.
    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,   // not a multiply-class op
        KIND_PLAIN = 2'd1,   // MULT/MULTU: product goes straight to HI/LO
        KIND_ADD   = 2'd2,   // MADD/MADDU: {HI,LO} + product
        KIND_SUB   = 2'd3    // MSUB/MSUBU: {HI,LO} - product
    } mul_kind_e;

    typedef struct packed {
        mul_kind_e kind;
        logic      is_signed;
    } mul_dec_t;

    function automatic mul_dec_t decode_op(input logic [7:0] op);
        mul_dec_t d;
        d.kind      = KIND_NONE;
        d.is_signed = 1'b0;
        case (op)
            EXE_MULT_OP:  begin d.kind = KIND_PLAIN; d.is_signed = 1'b1; end
            EXE_MULTU_OP: begin d.kind = KIND_PLAIN; d.is_signed = 1'b0; end
            EXE_MADD_OP:  begin d.kind = KIND_ADD;   d.is_signed = 1'b1; end
            EXE_MADDU_OP: begin d.kind = KIND_ADD;   d.is_signed = 1'b0; end
            EXE_MSUB_OP:  begin d.kind = KIND_SUB;   d.is_signed = 1'b1; end
            EXE_MSUBU_OP: begin d.kind = KIND_SUB;   d.is_signed = 1'b0; end
            default:      begin d.kind = KIND_NONE;  d.is_signed = 1'b0; end
        endcase
        return d;
    endfunction

endpackage : mul_ctrl_pkg

// ---------------------------------------------------------------------------
// mul_ctrl
//
// EX-stage sequencer for the six-cycle pipelined multiplier. It accepts a
// multiply-class op, holds start and the operands stable until the product
// returns, optionally accumulates the product into {HI,LO}, and finally
// issues a one-cycle HI/LO write. A flush while the multiplier is busy does
// not drop start early: the multiplier must run to completion so that its
// internal cycle counter stays aligned with this block.
//
// Ports
//   clk            rising-edge clock shared with the multiplier
//   rst            asynchronous reset, active low
//   aluop_i        EX-stage op code (non multiply-class codes are no-ops)
//   reg1_i/reg2_i  multiplicand / multiplier
//   hi_i/lo_i      current forwarded HI/LO (used by accumulate forms)
//   flush_i        pipeline flush
//   mul_result_i   64-bit product from the multiplier
//   mul_ready_i    product valid from the multiplier
//   mul_start_o    multiplier start, held while waiting
//   mul_signed_o   1 for signed forms
//   mul_op1_o/op2  multiplier operands
//   stallreq_o     pipeline stall request
//   whilo_o        HI/LO write enable (one-cycle pulse)
//   hi_o/lo_o      HI/LO write data
// ---------------------------------------------------------------------------
module mul_ctrl
    import mul_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        flush_i,
    input  logic [63:0] mul_result_i,
    input  logic        mul_ready_i,
    output logic        mul_start_o,
    output logic        mul_signed_o,
    output logic [31:0] mul_op1_o,
    output logic [31:0] mul_op2_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BUSY  = 3'd1,
        S_ACC   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_e;

    state_e      state_q,   state_d;
    logic [31:0] op1_q,     op1_d;
    logic [31:0] op2_q,     op2_d;
    mul_kind_e   kind_q,    kind_d;
    logic        signed_q,  signed_d;
    logic [63:0] product_q, product_d;
    logic [63:0] result_q,  result_d;

    mul_dec_t    dec;
    logic        is_mul;
    logic        accept;

    assign dec    = decode_op(aluop_i);
    assign is_mul = (dec.kind != KIND_NONE);

    // Acceptance is gated by rst so that every output is already 0 while the
    // reset is asserted, even with a multiply op sitting on aluop_i.
    assign accept = (state_q == S_IDLE) && is_mul && !flush_i && rst;

    // HI/LO write data is always the registered result; it is only
    // meaningful while whilo_o is high.
    assign hi_o = result_q[63:32];
    assign lo_o = result_q[31:0];

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        kind_d       = kind_q;
        signed_d     = signed_q;
        product_d    = product_q;
        result_d     = result_q;

        mul_start_o  = 1'b0;
        mul_signed_o = 1'b0;
        mul_op1_o    = 32'd0;
        mul_op2_o    = 32'd0;
        stallreq_o   = 1'b0;
        whilo_o      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // First EX cycle: operands go straight from the register file
                // to the multiplier so no cycle is lost.
                if (accept) begin
                    mul_start_o  = 1'b1;
                    stallreq_o   = 1'b1;
                    mul_op1_o    = reg1_i;
                    mul_op2_o    = reg2_i;
                    mul_signed_o = dec.is_signed;
                    op1_d        = reg1_i;
                    op2_d        = reg2_i;
                    kind_d       = dec.kind;
                    signed_d     = dec.is_signed;
                    state_d      = S_BUSY;
                end
            end

            S_BUSY: begin
                stallreq_o   = 1'b1;
                // Dropping start in the ready cycle stops the multiplier from
                // launching a second computation of the same operands.
                mul_start_o  = !mul_ready_i;
                mul_op1_o    = op1_q;
                mul_op2_o    = op2_q;
                mul_signed_o = signed_q;
                if (flush_i) begin
                    // If the product is arriving right now the multiplier is
                    // already finished, so there is nothing left to drain.
                    state_d = mul_ready_i ? S_IDLE : S_ABORT;
                end else if (mul_ready_i) begin
                    product_d = mul_result_i;
                    if (kind_q == KIND_PLAIN) begin
                        result_d = mul_result_i;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_ACC;
                    end
                end
            end

            S_ACC: begin
                stallreq_o = 1'b1;
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    // HI/LO are sampled here, after any older write-back has
                    // been forwarded. Wraps modulo 2^64 by construction.
                    if (kind_q == KIND_SUB) begin
                        result_d = {hi_i, lo_i} - product_q;
                    end else begin
                        result_d = {hi_i, lo_i} + product_q;
                    end
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // A flush in this cycle cancels the write; either way the op
                // leaves EX now.
                whilo_o = !flush_i;
                state_d = S_IDLE;
            end

            S_ABORT: begin
                // Drain the multiplier: start stays high with the original
                // operands until it reports ready, then the product is
                // dropped. A further flush has no effect here.
                mul_start_o  = !mul_ready_i;
                mul_op1_o    = op1_q;
                mul_op2_o    = op2_q;
                mul_signed_o = signed_q;
                // Only hold the pipeline if a new multiply is waiting for us.
                stallreq_o   = is_mul;
                if (mul_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and data registers
    // -----------------------------------------------------------------------
    // NOTE: non-blocking assignments here, so all registers update together
    // from values computed in the previous cycle regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op1_q     <= 32'd0;
            op2_q     <= 32'd0;
            kind_q    <= KIND_NONE;
            signed_q  <= 1'b0;
            product_q <= 64'd0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            kind_q    <= kind_d;
            signed_q  <= signed_d;
            product_q <= product_d;
            result_q  <= result_d;
        end
    end

endmodule : mul_ctrl

// File: tb/tb_mul_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mul_ctrl
//
// Drives mul_ctrl with directed and random multiply ops. A behavioural model
// of the six-cycle multiplier sits on the DUT's multiplier port. Expected
// HI/LO values come from plain 64-bit arithmetic on the op's operands, and
// expected handshake timing comes from the per-cycle timing table of an op
// (start in cycles 0-5, stall until the write cycle, write in cycle 7 or 8).
// ---------------------------------------------------------------------------
module tb_mul_ctrl;
    import mul_ctrl_pkg::*;

    localparam logic [7:0] NOP_OP = 8'h00;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
    logic        flush_i;
    logic [63:0] mul_result_i;
    logic        mul_ready_i;
    logic        mul_start_o, mul_signed_o, stallreq_o, whilo_o;
    logic [31:0] mul_op1_o, mul_op2_o, hi_o, lo_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_whilo_cyc = 0;

    mul_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .aluop_i      (aluop_i),
        .reg1_i       (reg1_i),
        .reg2_i       (reg2_i),
        .hi_i         (hi_i),
        .lo_i         (lo_i),
        .flush_i      (flush_i),
        .mul_result_i (mul_result_i),
        .mul_ready_i  (mul_ready_i),
        .mul_start_o  (mul_start_o),
        .mul_signed_o (mul_signed_o),
        .mul_op1_o    (mul_op1_o),
        .mul_op2_o    (mul_op2_o),
        .stallreq_o   (stallreq_o),
        .whilo_o      (whilo_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------------
    // Arithmetic helpers
    // ---------------------------------------------------------------------
    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    function automatic logic op_signed(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MADD_OP) || (op == EXE_MSUB_OP);
    endfunction

    function automatic logic op_acc(input logic [7:0] op);
        return !((op == EXE_MULT_OP) || (op == EXE_MULTU_OP));
    endfunction

    // Architectural result of a multiply op on {HI,LO}.
    function automatic logic [63:0] ref_hilo(input logic [7:0] op,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] h, input logic [31:0] l);
        logic [63:0] p;
        p = prod(a, b, op_signed(op));
        case (op)
            EXE_MULT_OP, EXE_MULTU_OP: return p;
            EXE_MADD_OP, EXE_MADDU_OP: return {h, l} + p;
            EXE_MSUB_OP, EXE_MSUBU_OP: return {h, l} - p;
            default:                   return 64'd0;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Multiplier model: needs start high for six consecutive cycles, then
    // presents the product for one cycle. Dropping start early abandons the
    // computation. Outside the ready cycle the result bus carries junk.
    // ---------------------------------------------------------------------
    logic [2:0]  m_cnt;
    logic [63:0] m_pend, m_res;
    logic        m_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt  <= 3'd0;
            m_pend <= 64'd0;
            m_res  <= 64'd0;
            m_rdy  <= 1'b0;
        end else begin
            m_rdy <= 1'b0;
            if (m_cnt == 3'd0) begin
                if (mul_start_o && !m_rdy) begin
                    m_pend <= prod(mul_op1_o, mul_op2_o, mul_signed_o);
                    m_cnt  <= 3'd1;
                end
            end else if (!mul_start_o) begin
                m_cnt <= 3'd0;
            end else if (m_cnt == 3'd5) begin
                m_cnt <= 3'd0;
                m_rdy <= 1'b1;
                m_res <= m_pend;
            end else begin
                m_cnt <= m_cnt + 3'd1;
            end
        end
    end

    assign mul_ready_i  = m_rdy;
    assign mul_result_i = m_rdy ? m_res : 64'hDEAD_BEEF_0BAD_F00D;

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".start"},  mul_start_o,  1'b0);
        check({tag, ".signed"}, mul_signed_o, 1'b0);
        check({tag, ".op1"},    mul_op1_o,    32'd0);
        check({tag, ".op2"},    mul_op2_o,    32'd0);
        check({tag, ".stall"},  stallreq_o,   1'b0);
        check({tag, ".whilo"},  whilo_o,      1'b0);
        check({tag, ".hi"},     hi_o,         32'd0);
        check({tag, ".lo"},     lo_o,         32'd0);
    endtask

    // One cycle with no accepted op: either a non-mul code, or a mul code
    // killed by a flush in IDLE.
    task automatic idle_cycle(input string tag, input logic [7:0] op, input logic fl);
        @(posedge clk); #1;
        aluop_i = op;
        reg1_i  = $urandom;
        reg2_i  = $urandom;
        hi_i    = $urandom;
        lo_i    = $urandom;
        flush_i = fl;
        @(negedge clk);
        check({tag, ".start"}, mul_start_o, 1'b0);
        check({tag, ".stall"}, stallreq_o,  1'b0);
        check({tag, ".whilo"}, whilo_o,     1'b0);
    endtask

    // Runs one op from its first EX cycle through its write cycle, holding
    // aluop_i while stalled. Operands and HI/LO inputs are only valid in the
    // cycles where the DUT is supposed to sample them. flush_k selects a
    // cycle (>= 7) in which flush_i is raised; 99 means no flush.
    task automatic run_op(input string tag, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l,
                          input logic [63:0] exp_hilo, input int flush_k);
        logic s, acc;
        int   n;
        s   = op_signed(op);
        acc = op_acc(op);
        n   = acc ? 9 : 8;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            aluop_i = (k > flush_k) ? NOP_OP : op;
            reg1_i  = (k == 0) ? a : 32'($urandom);
            reg2_i  = (k == 0) ? b : 32'($urandom);
            hi_i    = (acc && k == 7) ? h : 32'($urandom);
            lo_i    = (acc && k == 7) ? l : 32'($urandom);
            flush_i = (k == flush_k);
            @(negedge clk);
            if (k > flush_k) begin
                check({tag, ".post_flush.stall"}, stallreq_o,  1'b0);
                check({tag, ".post_flush.start"}, mul_start_o, 1'b0);
                check({tag, ".post_flush.whilo"}, whilo_o,     1'b0);
            end else begin
                check({tag, ".stall"}, stallreq_o,  k < n - 1);
                check({tag, ".start"}, mul_start_o, k <= 5);
                check({tag, ".whilo"}, whilo_o,     (k == n - 1) && (k != flush_k));
                if (k <= 5) begin
                    check({tag, ".signed"}, mul_signed_o, s);
                    check({tag, ".op1"},    mul_op1_o,    a);
                    check({tag, ".op2"},    mul_op2_o,    b);
                end
                if ((k == n - 1) && (k != flush_k)) begin
                    check({tag, ".hi"}, hi_o, exp_hilo[63:32]);
                    check({tag, ".lo"}, lo_o, exp_hilo[31:0]);
                    last_whilo_cyc = cyc;
                end
            end
        end
        flush_i = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    localparam logic [7:0] OPS [6] = '{EXE_MULT_OP, EXE_MULTU_OP, EXE_MADD_OP,
                                        EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP};

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int first_done;
        aluop_i = NOP_OP;
        reg1_i  = 32'd0;
        reg2_i  = 32'd0;
        hi_i    = 32'd0;
        lo_i    = 32'd0;
        flush_i = 1'b0;
        rst     = 1'b1;
        #1 rst  = 1'b0;

        // Reset state
        #10;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        idle_cycle("idle_nop", NOP_OP, 1'b0);

        // Directed ops
        run_op("mult_neg", EXE_MULT_OP, 32'hFFFF_FFFF, 32'h0000_0002, 32'd0, 32'd0,
               64'hFFFF_FFFF_FFFF_FFFE, 99);
        idle_cycle("gap1", NOP_OP, 1'b0);
        run_op("multu", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'h0000_0002, 32'd0, 32'd0,
               64'h0000_0001_FFFF_FFFE, 99);
        idle_cycle("gap2", NOP_OP, 1'b0);
        run_op("madd", EXE_MADD_OP, 32'd3, 32'd4, 32'd0, 32'd1,
               64'h0000_0000_0000_000D, 99);
        idle_cycle("gap3", NOP_OP, 1'b0);
        run_op("msubu_wrap", EXE_MSUBU_OP, 32'd1, 32'd1, 32'd0, 32'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 99);

        // Back-to-back MULT then MULTU: second accepted right after DONE
        run_op("b2b_1", EXE_MULT_OP, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0,
               64'h0000_0001_0000_0000, 99);
        first_done = last_whilo_cyc;
        run_op("b2b_2", EXE_MULTU_OP, 32'h8000_0000, 32'd2, 32'd0, 32'd0,
               64'h0000_0001_0000_0000, 99);
        check("b2b.gap", 64'(last_whilo_cyc - first_done), 64'd8);

        // Flush in IDLE: op is not accepted
        idle_cycle("flush_idle", EXE_MULT_OP, 1'b1);

        // Flush in cycle 3 of a MULT -> drain, new MULT waits in ABORT
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            aluop_i = (k == 4) ? NOP_OP : EXE_MULT_OP;
            reg1_i  = (k == 0) ? 32'h1234_5678 : ((k >= 5) ? 32'd7 : 32'($urandom));
            reg2_i  = (k == 0) ? 32'h0000_0010 : ((k >= 5) ? 32'd9 : 32'($urandom));
            flush_i = (k == 3) || (k == 4);
            @(negedge clk);
            check("abort.whilo", whilo_o, 1'b0);
            check("abort.start", mul_start_o, k <= 5);
            check("abort.stall", stallreq_o, k != 4);
            if (k >= 4 && k <= 5) begin
                check("abort.op1", mul_op1_o, 32'h1234_5678);
                check("abort.op2", mul_op2_o, 32'h0000_0010);
            end
        end
        flush_i = 1'b0;
        run_op("after_abort", EXE_MULT_OP, 32'd7, 32'd9, 32'd0, 32'd0, 64'd63, 99);

        // Flush in DONE and in ACC cancel the write
        run_op("flush_done", EXE_MULT_OP, 32'd5, 32'd5, 32'd0, 32'd0, 64'd25, 7);
        run_op("flush_acc", EXE_MADD_OP, 32'd5, 32'd5, 32'd0, 32'd0, 64'd25, 7);
        idle_cycle("gap4", NOP_OP, 1'b0);

        // Async reset in cycle 4 of a MADD
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            aluop_i = EXE_MADD_OP;
            reg1_i  = 32'd11;
            reg2_i  = 32'd13;
            if (k == 4) begin
                #2 rst = 1'b0;
                #1 check_all_zero("rst_mid");
            end
        end
        @(negedge clk);
        check_all_zero("rst_held");
        aluop_i = NOP_OP;
        @(negedge clk);
        rst = 1'b1;
        run_op("post_rst", EXE_MULT_OP, 32'd2, 32'd5, 32'd0, 32'd0, 64'h0000_0000_0000_000A, 99);

        // Random ops, gaps, IDLE flushes and late flushes
        for (int i = 0; i < 40; i++) begin
            logic [7:0]  op;
            logic [31:0] a, b, h, l;
            int          fk;
            op = OPS[$urandom_range(0, 5)];
            a  = rand_word();
            b  = rand_word();
            h  = rand_word();
            l  = rand_word();
            fk = 99;
            if ($urandom_range(0, 4) == 0) begin
                fk = op_acc(op) ? int'($urandom_range(7, 8)) : 7;
            end
            case ($urandom_range(0, 3))
                0: idle_cycle("rnd_gap", NOP_OP, 1'b0);
                1: idle_cycle("rnd_flush_idle", OPS[$urandom_range(0, 5)], 1'b1);
                default: ;
            endcase
            run_op("rnd", op, a, b, h, l, ref_hilo(op, a, b, h, l), fk);
        end

        idle_cycle("final", NOP_OP, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mul_ctrl
